// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Optional match counter is enabled by defining SEQ_DET_MATCH_CNT_EN.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } seq_det_state_t;

    // Widest pattern the mask helper can describe; the top slices it to MAX_LEN.
    localparam int unsigned SEQ_DET_MASK_W = 64;

    function automatic logic [SEQ_DET_MASK_W-1:0] len_mask(input int unsigned len);
        logic [SEQ_DET_MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < SEQ_DET_MASK_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; an increment on the clearing edge
// is kept so that event is not lost.
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector with overlapping/non-overlapping modes.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic                         cfg_load,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         rx_valid,
    input  logic                         rx,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cfg_err,
    output logic                         armed
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    seq_det_state_t state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               cfg_ok_q, cfg_ok_d;
    logic               cfg_err_q, cfg_err_d;
    logic               match_q, match_d;

    logic [SEQ_DET_MASK_W-1:0] mask_wide;
    logic [MAX_LEN-1:0]        mask, hist_nxt;
    logic                      cfg_valid, full;

    always_comb begin
        mask_wide = len_mask(32'(len_q));
        mask      = mask_wide[MAX_LEN-1:0];
        hist_nxt  = {hist_q[MAX_LEN-2:0], rx};
        cfg_valid = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
        full      = (fill_q >= (len_q - LEN_ONE));

        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        cfg_ok_d  = cfg_ok_q;
        cfg_err_d = cfg_err_q;
        match_d   = 1'b0;

        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
            if (cfg_valid) begin
                pat_d     = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                cfg_ok_d  = 1'b1;
                cfg_err_d = 1'b0;
                state_d   = en ? FILL : IDLE;
            end else begin
                // Old pattern is retained but not used until a good load re-arms.
                cfg_ok_d  = 1'b0;
                cfg_err_d = 1'b1;
                state_d   = IDLE;
            end
        end else if (!en) begin
            state_d = IDLE;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_ok_q) state_d = (len_q == LEN_ONE) ? HUNT : FILL;
                end
                FILL, HUNT: begin
                    if (rx_valid) begin
                        hist_d = hist_nxt;
                        if (fill_q != len_q) fill_d = fill_q + LEN_ONE;
                        if (full) begin
                            state_d = HUNT;
                            if ((hist_nxt & mask) == (pat_q & mask)) begin
                                match_d = 1'b1;
                                if (!overlap_q) begin
                                    fill_d  = '0;
                                    state_d = FILL;
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            cfg_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            cfg_ok_q  <= cfg_ok_d;
            cfg_err_q <= cfg_err_d;
            match_q   <= match_d;
        end
    end

    assign match   = match_q;
    assign cfg_err = cfg_err_q;
    assign armed   = (state_q == FILL) || (state_q == HUNT);

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (match_d),
        .clr  (cnt_clr),
        .cnt  (match_cnt)
    );
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed self-checking bench for seq_pattern_detector (MAX_LEN=16, CNT_W=2).
module tb_seq_pattern_detector;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned LEN_W   = 5;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic               clk, rstn, en, cfg_load, cfg_overlap, rx_valid, rx, cnt_clr;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               match, cfg_err, armed;
    logic [CNT_W-1:0]   match_cnt;

    int checks = 0;
    int errors = 0;

    logic stream [7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_ov1 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_ov0 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    seq_pattern_detector #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .rx_valid    (rx_valid),
        .rx          (rx),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err),
        .armed       (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned ecnt(input int unsigned n);
        return CNT_EN ? n : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        rx_valid = v;
        rx       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ov);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_load    = 1'b1;
        rx_valid    = 1'b0;
        @(posedge clk);
        #1;
        cfg_load    = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        cnt_clr = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; rx_valid = 1'b0; rx = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match", 32'(match), 0);
        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_armed", 32'(armed), 0);
        rstn = 1'b1;
        en   = 1'b1;
        step(1'b1, 1'b0);
        chk("noconfig_armed", 32'(armed), 0);

        // Overlapping 0110 over 0110110
        load(16'h0006, 5'd4, 1'b1);
        chk("t1_armed", 32'(armed), 1);
        chk("t1_cfg_err", 32'(cfg_err), 0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream[i]);
            chk($sformatf("t1_match_bit%0d", i + 1), 32'(match), 32'(exp_ov1[i]));
        end
        step(1'b0, 1'b0);
        chk("t1_match_pulse_end", 32'(match), 0);
        chk("t1_cnt", 32'(match_cnt), ecnt(2));
        clear_cnt();
        chk("clr_alone", 32'(match_cnt), 0);

        // Non-overlapping on the same stream
        load(16'h0006, 5'd4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, stream[i]);
            chk($sformatf("t2_match_bit%0d", i + 1), 32'(match), 32'(exp_ov0[i]));
        end
        step(1'b0, 1'b0);
        chk("t2_cnt", 32'(match_cnt), ecnt(1));
        clear_cnt();

        // rx_valid gap between bits 2 and 3
        load(16'h0006, 5'd4, 1'b1);
        step(1'b1, 1'b0);
        chk("t3_b1", 32'(match), 0);
        step(1'b1, 1'b1);
        chk("t3_b2", 32'(match), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            chk($sformatf("t3_gap%0d", i), 32'(match), 0);
        end
        step(1'b1, 1'b1);
        chk("t3_b3", 32'(match), 0);
        step(1'b1, 1'b0);
        chk("t3_b4", 32'(match), 1);
        step(1'b0, 1'b0);
        chk("t3_pulse_end", 32'(match), 0);
        chk("t3_cnt", 32'(match_cnt), ecnt(1));

        // Illegal lengths
        load(16'h0006, 5'd0, 1'b1);
        chk("t4_len0_err", 32'(cfg_err), 1);
        chk("t4_len0_armed", 32'(armed), 0);
        load(16'h0006, 5'd17, 1'b1);
        chk("t4_len17_err", 32'(cfg_err), 1);
        chk("t4_len17_armed", 32'(armed), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, stream[i]);
            chk($sformatf("t4_nomatch%0d", i), 32'(match), 0);
        end
        chk("t4_err_sticky", 32'(cfg_err), 1);
        chk("t4_armed_after", 32'(armed), 0);
        load(16'h0006, 5'd4, 1'b1);
        chk("t4_reload_err", 32'(cfg_err), 0);
        chk("t4_reload_armed", 32'(armed), 1);

        // Saturation with len=1 pattern '1'
        clear_cnt();
        load(16'h0001, 5'd1, 1'b1);
        chk("t5_armed", 32'(armed), 1);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("t5_match%0d", i), 32'(match), 1);
            chk($sformatf("t5_cnt%0d", i), 32'(match_cnt), ecnt((i > 3) ? 3 : i));
        end
        step(1'b1, 1'b0);
        chk("t5_len1_miss", 32'(match), 0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        chk("t5_clr_with_match", 32'(match_cnt), ecnt(1));
        chk("t5_clr_match", 32'(match), 1);
        clear_cnt();
        chk("t5_clr_alone", 32'(match_cnt), 0);

        // en dropped mid-pattern clears history
        load(16'h0006, 5'd4, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("t6_pre_en_match", 32'(match), 0);
        en = 1'b0;
        step(1'b0, 1'b0);
        chk("t6_en0_armed", 32'(armed), 0);
        en = 1'b1;
        step(1'b0, 1'b0);
        chk("t6_en1_armed", 32'(armed), 1);
        step(1'b1, 1'b0);
        chk("t6_no_match", 32'(match), 0);
        en = 1'b0;
        step(1'b0, 1'b0);
        chk("t6_en0b_armed", 32'(armed), 0);

        // Async reset mid-stream, with match high and count nonzero
        en = 1'b1;
        step(1'b0, 1'b0);
        clear_cnt();
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("t6_pre_rst_match", 32'(match), 1);
        chk("t6_pre_rst_cnt", 32'(match_cnt), ecnt(1));
        rx_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_arst_match", 32'(match), 0);
        chk("t6_arst_cnt", 32'(match_cnt), 0);
        chk("t6_arst_armed", 32'(armed), 0);
        chk("t6_arst_cfg_err", 32'(cfg_err), 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t6_post_rst_armed", 32'(armed), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, stream[i]);
            chk($sformatf("t6_post_rst_nomatch%0d", i), 32'(match), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
